pyr_rate_scheduler: RTL and testbench
=====================================

Name: pyr_rate_scheduler

Overview:
Sequences the pyramidal LK level engine from the coarsest level to the finest (level NUM_LEVELS-1 down to 0). Level k runs at clk/2^k. The block replaces derived divided clocks with a single-clock counter that produces clock-enable strobes. For each level it issues a start pulse aligned to that level's enable, waits for the level's done under an optional timeout, then moves to the next level. It sits between the top-level frame controller and the shared LK level datapath.

Parameters:
NUM_LEVELS, 3, number of pyramid levels; legal range 1..4.
TMO_W, 16, width of the timeout counter and of timeout_max.

Ports:
clk  in  1  system clock; the only clock in the block.
reset  in  1  asynchronous, active-high.
start  in  1  one-cycle request to process one frame; ignored while busy.
abort  in  1  synchronous abort; returns to IDLE from any state.
timeout_max  in  TMO_W  maximum enabled cycles per level; 0 disables the timeout.
lvl_done  in  1  level engine finished; sampled only on cycles where ce_cur=1.
ce_vec  out  NUM_LEVELS  free-running enable strobes; bit k is high one cycle in every 2^k.
ce_cur  out  1  equals ce_vec[level]; gates the level datapath.
lvl_start  out  1  one-cycle start pulse to the level engine.
level  out  2  index of the level currently being processed.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when level 0 completes.
err  out  1  sticky timeout flag.

Behaviour:
- Reset: cnt=0, state=IDLE, level=0, err=0, timer=0. Consequently lvl_start=0, done=0, busy=0, ce_vec[0]=1 and all other ce_vec bits are 0.
- Rate counter:
  - cnt is a 3-bit register that increments every clk and wraps 7->0. It never stops, including in IDLE and ERR.
  - ce_vec[0]=1 always. For k>=1, ce_vec[k] = AND of cnt[k-1:0].
  - Bit 1 is high at cnt=1,3,5,7. Bit 2 is high at cnt=3,7. Bit 3 is high at cnt=7.
  - ce_vec is decoded from a register only, so it is glitch-free.
- FSM states: IDLE, WAIT_CE, RUN, DONE.
  - IDLE: start=1 -> level<=NUM_LEVELS-1, err<=0, go to WAIT_CE.
  - WAIT_CE: on the first cycle with ce_cur=1, assert lvl_start (Mealy output, same cycle), set timer<=0, go to RUN. If ce_cur=1 on the first WAIT_CE cycle, lvl_start fires immediately.
  - RUN: only cycles with ce_cur=1 are evaluated; other cycles hold state.
    - lvl_done=1 with level=0 -> go to DONE.
    - lvl_done=1 with level>0 -> level<=level-1, go to WAIT_CE.
    - lvl_done=0 with timeout_max!=0 and timer==timeout_max-1 -> err<=1, go to IDLE, no done.
    - lvl_done=0 otherwise -> timer<=timer+1.
    - lvl_done and timeout on the same enabled cycle: lvl_done wins.
  - DONE: done=1 for exactly one cycle, then go to IDLE. level stays 0.
- lvl_start and done are never high in the same cycle. lvl_start is at most one pulse per level per frame.
- lvl_done asserted while ce_cur=0, or outside RUN, is ignored.
- start while busy=1 is ignored; there is no queueing.
- start on the DONE cycle is ignored. start on the first IDLE cycle after DONE is accepted.
- abort=1:
  - Takes priority over every other transition.
  - Next state is IDLE and level<=0.
  - No done and no lvl_start are generated in the abort cycle.
  - err keeps its value.
- Asynchronous reset mid-frame forces the reset values immediately; cnt restarts from 0.
- Latency, with start accepted in cycle t:
  - lvl_start for the first level occurs at the first cycle >= t+1 where ce_vec[NUM_LEVELS-1]=1.
  - Each following level's lvl_start occurs at the first cycle, at or after the lvl_done acceptance cycle +1, where the new level's enable is high.
- NUM_LEVELS=1: only level 0 is used, so ce_cur=1 constantly.
- Unused upper ce_vec bits do not exist; ce_vec width equals NUM_LEVELS.

Test Plan:
1. Reset deasserted, idle for 16 cycles -> ce_vec[1] high when cnt is odd; ce_vec[2] high at cnt=3 and 7; busy=0, done=0, err=0, level=0.
2. NUM_LEVELS=3, timeout_max=0, start at cnt=0; engine asserts lvl_done on its 4th enabled cycle after each lvl_start -> lvl_start fires at level 2 (cnt=3), level 1, then level 0, each coincident with its ce strobe; done pulses once, then busy=0.
3. timeout_max=5, lvl_done never asserted at level 2 -> after 5 enabled RUN cycles (about 20 clk), err=1, busy=0, done=0; a later start clears err.
4. Second start pulse during RUN at level 1 -> ignored; exactly 3 lvl_start pulses and 1 done pulse for the frame.
5. abort during RUN at level 1 -> IDLE on the next cycle, level=0, no done; new start restarts at level 2. Repeat with asynchronous reset mid-frame -> all outputs at reset values immediately.
6. lvl_done held high while ce_cur=0 at level 2 -> ignored until the next ce_vec[2] cycle; lvl_done and timeout on the same enabled cycle -> level advances, err stays 0.

Source files
------------

// File: rtl/pyr_rate_scheduler.sv
// Pyramid level sequencer: single-clock rate counter produces per-level enables,
// and an FSM walks levels coarsest to finest with start/done handshakes and a timeout.
module pyr_rate_scheduler #(
    parameter int NUM_LEVELS = 3,
    parameter int TMO_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TMO_W-1:0]      timeout_max,
    input  logic                  lvl_done,
    output logic [NUM_LEVELS-1:0] ce_vec,
    output logic                  ce_cur,
    output logic                  lvl_start,
    output logic [1:0]            level,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CE,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0]       LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [TMO_W-1:0] TMO_ONE    = 1;

    state_t           state, state_n;
    logic [2:0]       cnt;
    logic [3:0]       ce_all;
    logic [1:0]       level_n;
    logic [TMO_W-1:0] timer, timer_n;
    logic             err_n;

    // Enables are decoded from the counter register only, so they never glitch.
    assign ce_all = {&cnt[2:0], &cnt[1:0], cnt[0], 1'b1};
    assign ce_vec = ce_all[NUM_LEVELS-1:0];
    assign ce_cur = ce_all[level];
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            state <= IDLE;
            level <= '0;
            timer <= '0;
            err   <= 1'b0;
        end else begin
            cnt   <= cnt + 3'd1;
            state <= state_n;
            level <= level_n;
            timer <= timer_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        level_n   = level;
        timer_n   = timer;
        err_n     = err;
        lvl_start = 1'b0;
        done      = 1'b0;
        if (abort) begin
            state_n = IDLE;
            level_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        level_n = LAST_LEVEL;
                        err_n   = 1'b0;
                        state_n = WAIT_CE;
                    end
                end
                WAIT_CE: begin
                    if (ce_cur) begin
                        lvl_start = 1'b1;
                        timer_n   = '0;
                        state_n   = RUN;
                    end
                end
                RUN: begin
                    // lvl_done is checked before the timeout so completion wins a tie.
                    if (ce_cur) begin
                        if (lvl_done) begin
                            if (level == 2'd0) begin
                                state_n = DONE;
                            end else begin
                                level_n = level - 2'd1;
                                state_n = WAIT_CE;
                            end
                        end else if ((timeout_max != '0) &&
                                     (timer == timeout_max - TMO_ONE)) begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            timer_n = timer + TMO_ONE;
                        end
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pyr_rate_scheduler.sv
// Scoreboard bench for pyr_rate_scheduler: expected lvl_start/done events are queued
// with hand-computed cycle numbers and matched by a negedge monitor.
module tb_pyr_rate_scheduler;

    localparam int NL = 3;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [TW-1:0] timeout_max;
    logic          lvl_done;
    logic [NL-1:0] ce_vec;
    logic          ce_cur;
    logic          lvl_start;
    logic [1:0]    level;
    logic          busy;
    logic          done;
    logic          err;

    pyr_rate_scheduler #(.NUM_LEVELS(NL), .TMO_W(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .timeout_max(timeout_max), .lvl_done(lvl_done), .ce_vec(ce_vec),
        .ce_cur(ce_cur), .lvl_start(lvl_start), .level(level), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; equals the DUT rate counter modulo 8.
    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit         is_done;
        logic [1:0] lvl;
        int         cycle;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [2:0] ce_model(input int c);
        int m;
        logic [2:0] r;
        m = c % 8;
        r[0] = 1'b1;
        r[1] = (m == 1) || (m == 3) || (m == 5) || (m == 7);
        r[2] = (m == 3) || (m == 7);
        return r;
    endfunction

    task automatic push_ev(input bit is_done, input logic [1:0] lvl, input int c);
        ev_t e;
        e.is_done = is_done;
        e.lvl     = lvl;
        e.cycle   = c;
        exp_q.push_back(e);
    endtask

    task automatic at_cycle(input int n);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc < n && guard < 500);
        if (cyc != n) begin
            vectors++;
            miscompares++;
            $display("FAIL at_cycle: actual %0d required %0d", cyc, n);
        end
    endtask

    always @(negedge clk) begin
        check("ce_vec", 32'(ce_vec), 32'(ce_model(cyc)));
        if (!reset && (lvl_start || done)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: actual lvl_start=%0b done=%0b level=%0d, required none (cycle %0d)",
                         lvl_start, done, level, cyc);
            end else begin
                ev = exp_q.pop_front();
                check("event_is_done", 32'(done), 32'(ev.is_done));
                check("event_level", 32'(level), 32'(ev.lvl));
                check("event_cycle", cyc, ev.cycle);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; lvl_done = 1'b0; timeout_max = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_level", 32'(level), 0);
        check("rst_lvl_start", 32'(lvl_start), 0);
        reset = 1'b0;

        // Idle: monitor checks ce_vec every cycle.
        at_cycle(15);
        check("idle_busy", 32'(busy), 0);
        check("idle_level", 32'(level), 0);
        check("idle_done", 32'(done), 0);

        // Full frame, lvl_done on 4th enabled cycle, plus ignored start at level 1.
        at_cycle(16);
        push_ev(0, 2, 19); push_ev(0, 1, 37); push_ev(0, 0, 46); push_ev(1, 0, 51);
        start = 1'b1;
        at_cycle(17); start = 1'b0;
        check("f1_busy", 32'(busy), 1);
        check("f1_level", 32'(level), 2);
        at_cycle(35); lvl_done = 1'b1;
        at_cycle(36); lvl_done = 1'b0;
        at_cycle(41); start = 1'b1;
        at_cycle(42); start = 1'b0;
        check("f1_level_after_start", 32'(level), 1);
        at_cycle(45); lvl_done = 1'b1;
        at_cycle(46); lvl_done = 1'b0;
        at_cycle(50); lvl_done = 1'b1;
        at_cycle(51); lvl_done = 1'b0;
        at_cycle(52);
        check("f1_end_busy", 32'(busy), 0);
        check("f1_end_err", 32'(err), 0);

        // Timeout after 5 enabled RUN cycles at level 2.
        at_cycle(56);
        timeout_max = 16'd5;
        push_ev(0, 2, 59);
        start = 1'b1;
        at_cycle(57); start = 1'b0;
        at_cycle(79);
        check("tmo_err_before", 32'(err), 0);
        check("tmo_busy_before", 32'(busy), 1);
        at_cycle(80);
        check("tmo_err", 32'(err), 1);
        check("tmo_busy", 32'(busy), 0);

        // New start clears err; abort during level 1.
        at_cycle(88);
        timeout_max = '0;
        push_ev(0, 2, 91); push_ev(0, 1, 97);
        start = 1'b1;
        at_cycle(89); start = 1'b0;
        check("restart_err_clear", 32'(err), 0);
        check("restart_level", 32'(level), 2);
        at_cycle(95); lvl_done = 1'b1;
        at_cycle(96); lvl_done = 1'b0;
        at_cycle(99); abort = 1'b1;
        at_cycle(100); abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_level", 32'(level), 0);
        check("abort_err", 32'(err), 0);

        // Restart, then asynchronous reset mid-frame.
        at_cycle(104);
        push_ev(0, 2, 107);
        start = 1'b1;
        at_cycle(105); start = 1'b0;
        at_cycle(109);
        check("pre_areset_busy", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("areset_busy", 32'(busy), 0);
        check("areset_level", 32'(level), 0);
        check("areset_ce_vec", 32'(ce_vec), 1);
        check("areset_lvl_start", 32'(lvl_start), 0);
        check("areset_done", 32'(done), 0);
        check("areset_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // lvl_done held while ce_cur=0; lvl_done ties with timeout.
        at_cycle(8);
        push_ev(0, 2, 11); push_ev(0, 1, 17); push_ev(0, 0, 20); push_ev(1, 0, 22);
        start = 1'b1;
        at_cycle(9); start = 1'b0;
        at_cycle(12); lvl_done = 1'b1;
        at_cycle(14);
        check("hold_level_ignored", 32'(level), 2);
        at_cycle(16); lvl_done = 1'b0;
        check("hold_level_advanced", 32'(level), 1);
        at_cycle(17); timeout_max = 16'd1;
        at_cycle(19); lvl_done = 1'b1;
        at_cycle(20); lvl_done = 1'b0;
        check("tie_level", 32'(level), 0);
        check("tie_err", 32'(err), 0);
        at_cycle(21); lvl_done = 1'b1;
        at_cycle(22); lvl_done = 1'b0;
        at_cycle(23);
        check("tie_end_err", 32'(err), 0);
        check("tie_end_busy", 32'(busy), 0);

        at_cycle(30);
        check("events_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
